// File: rtl/spike_window_decoder.sv
// Counts per-neuron spike rising edges over a fixed window, thresholds them into a
// recalled pattern plus most-active neuron, and holds the result until handshaked.
module spike_window_decoder #(
    parameter int N      = 7,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4,
    parameter int IDX_W  = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [N-1:0]     spikes_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [N-1:0]     pattern_out_o,
    output logic [IDX_W-1:0] winner_o,
    output logic             winner_valid_o,
    output logic             busy_o
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE, S_HOLD} state_t;

    state_t             state_q;
    logic [WIN_W-1:0]   win_q;
    logic [CNT_W-1:0]   cnt_q [N];
    logic [N-1:0]       spikes_prev_q;
    logic               out_valid_q, winner_valid_q, busy_q;
    logic [N-1:0]       pattern_q;
    logic [IDX_W-1:0]   winner_q;

    logic [N-1:0]       event_d;
    logic [CNT_W-1:0]   cnt_d [N];
    logic [CNT_W-1:0]   best_d;
    logic [N-1:0]       pattern_d;
    logic [IDX_W-1:0]   winner_d;

    // Scoring is evaluated from the frozen counts during the DONE cycle, keeping the
    // winner scan out of the counting path.
    always_comb begin
        event_d   = spikes_i & ~spikes_prev_q;
        best_d    = '0;
        winner_d  = '0;
        pattern_d = '0;
        for (int k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
            if (event_d[k] && (cnt_q[k] != CNT_MAX))
                cnt_d[k] = cnt_q[k] + 1'b1;
            pattern_d[k] = (32'(cnt_q[k]) >= THRESH);
            if (cnt_q[k] > best_d) begin
                best_d   = cnt_q[k];
                winner_d = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            win_q          <= '0;
            spikes_prev_q  <= '0;
            out_valid_q    <= 1'b0;
            pattern_q      <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            for (int k = 0; k < N; k++) cnt_q[k] <= '0;
        end else begin
            spikes_prev_q <= spikes_i;
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_COUNT;
                        busy_q  <= 1'b1;
                        win_q   <= '0;
                        for (int k = 0; k < N; k++) cnt_q[k] <= '0;
                    end
                end
                S_COUNT: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        win_q   <= '0;
                        for (int k = 0; k < N; k++) cnt_q[k] <= '0;
                    end else begin
                        for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
                        if (win_q == WIN_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            win_q   <= '0;
                        end else begin
                            win_q <= win_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q        <= S_HOLD;
                    out_valid_q    <= 1'b1;
                    pattern_q      <= pattern_d;
                    winner_q       <= winner_d;
                    winner_valid_q <= (best_d != '0);
                end
                S_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        win_q       <= '0;
                        for (int k = 0; k < N; k++) cnt_q[k] <= '0;
                        state_q     <= enable_i ? S_COUNT : S_IDLE;
                        busy_q      <= enable_i;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o    = out_valid_q;
    assign pattern_out_o  = pattern_q;
    assign winner_o       = winner_q;
    assign winner_valid_o = winner_valid_q;
    assign busy_o         = busy_q;

endmodule
